// File: rtl/bit_collect_pkg.sv
// Shared definitions for the single-bit start/work handshake stream.
// The state encoding is fixed so the streamer side can decode the same values.
package bit_collect_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_ARM      = 4'd1,
    ST_WAIT_BIT = 4'd2,
    ST_WRITE    = 4'd3,
    ST_DLY      = 4'd4,
    ST_ACK      = 4'd5,
    ST_WAIT_LOW = 4'd6,
    ST_DONE     = 4'd7,
    ST_RELEASE  = 4'd8
  } state_e;

  localparam logic HS_IDLE   = 1'b0;
  localparam logic HS_ACTIVE = 1'b1;

  localparam int unsigned ACK_DELAY_W = 4;

endpackage

// File: rtl/bit_collect_ack_timer.sv
// Down-counter that spaces the BRAM write from the upstream acknowledge.
// Loaded with the delay on the write cycle; done on the last delay cycle.
module bit_collect_ack_timer
  import bit_collect_pkg::*;
#(
  parameter int unsigned ACK_DELAY = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic en_i,
  output logic done_o
);

  logic [ACK_DELAY_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = ACK_DELAY_W'(ACK_DELAY);
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A count of one is the final delay cycle, so the FSM leaves DLY on it.
  assign done_o = (cnt_q <= ACK_DELAY_W'(1));

endmodule

// File: rtl/bit_collect.sv
// Collects one bit per upstream work handshake into a 1-bit BRAM (port A)
// and hands the filled buffer downstream with a start/finish handshake.
module bit_collect
  import bit_collect_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH_3 = 12,
  parameter int unsigned ACK_DELAY    = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    im_start,
  input  logic                    im_work,
  input  logic                    im_data,
  output logic                    om_work,
  output logic [ADDR_WIDTH_3-1:0] addra,
  output logic                    dina,
  output logic                    wea,
  input  logic [ADDR_WIDTH_3-1:0] addra_begin,
  output logic [ADDR_WIDTH_3-1:0] addra_end,
  output logic [ADDR_WIDTH_3:0]   bit_cnt,
  output logic                    om_ovf,
  output logic                    om_start,
  input  logic                    im_finish
);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH_3-1:0] base_q, base_d;
  logic [ADDR_WIDTH_3-1:0] addra_q, addra_d;
  logic [ADDR_WIDTH_3-1:0] addra_end_q, addra_end_d;
  logic [ADDR_WIDTH_3:0]   bit_cnt_q, bit_cnt_d;
  logic                    first_q, first_d;
  logic                    dina_q, dina_d;
  logic                    wea_q, wea_d;
  logic                    om_work_q, om_work_d;
  logic                    om_start_q, om_start_d;
  logic                    ovf_q, ovf_d;
  logic                    tmr_load, tmr_en, tmr_done;

  bit_collect_ack_timer #(
    .ACK_DELAY(ACK_DELAY)
  ) u_ack_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load_i(tmr_load),
    .en_i  (tmr_en),
    .done_o(tmr_done)
  );

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    addra_d     = addra_q;
    addra_end_d = addra_end_q;
    bit_cnt_d   = bit_cnt_q;
    first_d     = first_q;
    dina_d      = dina_q;
    wea_d       = 1'b0;
    om_work_d   = om_work_q;
    om_start_d  = om_start_q;
    ovf_d       = ovf_q;
    tmr_load    = 1'b0;
    tmr_en      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (im_start) begin
          base_d      = addra_begin;
          addra_end_d = addra_begin;
          bit_cnt_d   = '0;
          ovf_d       = 1'b0;
          first_d     = 1'b1;
          state_d     = ST_ARM;
        end
      end
      ST_ARM: state_d = ST_WAIT_BIT;
      ST_WAIT_BIT: begin
        if (im_work) begin
          dina_d  = im_data;
          state_d = ST_WRITE;
        end else if (!im_start) begin
          om_start_d = HS_ACTIVE;
          state_d    = ST_DONE;
        end
      end
      ST_WRITE: begin
        // MSB of the count set means the buffer already holds 2^ADDR_WIDTH_3 bits.
        if (!bit_cnt_q[ADDR_WIDTH_3]) begin
          wea_d       = 1'b1;
          addra_d     = first_q ? base_q : addra_q + 1'b1;
          addra_end_d = addra_d;
          bit_cnt_d   = bit_cnt_q + 1'b1;
          first_d     = 1'b0;
        end else begin
          ovf_d = 1'b1;
        end
        tmr_load = 1'b1;
        state_d  = (ACK_DELAY == 0) ? ST_ACK : ST_DLY;
      end
      ST_DLY: begin
        tmr_en = 1'b1;
        if (tmr_done) state_d = ST_ACK;
      end
      ST_ACK: begin
        om_work_d = HS_ACTIVE;
        state_d   = ST_WAIT_LOW;
      end
      ST_WAIT_LOW: begin
        if (!im_work) begin
          om_work_d = HS_IDLE;
          state_d   = ST_WAIT_BIT;
        end
      end
      ST_DONE: begin
        if (im_finish) begin
          om_start_d = HS_IDLE;
          state_d    = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (!im_finish && !im_start) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      base_q      <= '0;
      addra_q     <= '0;
      addra_end_q <= '0;
      bit_cnt_q   <= '0;
      first_q     <= 1'b0;
      dina_q      <= 1'b0;
      wea_q       <= 1'b0;
      om_work_q   <= 1'b0;
      om_start_q  <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      addra_q     <= addra_d;
      addra_end_q <= addra_end_d;
      bit_cnt_q   <= bit_cnt_d;
      first_q     <= first_d;
      dina_q      <= dina_d;
      wea_q       <= wea_d;
      om_work_q   <= om_work_d;
      om_start_q  <= om_start_d;
      ovf_q       <= ovf_d;
    end
  end

  assign om_work   = om_work_q;
  assign addra     = addra_q;
  assign dina      = dina_q;
  assign wea       = wea_q;
  assign addra_end = addra_end_q;
  assign bit_cnt   = bit_cnt_q;
  assign om_ovf    = ovf_q;
  assign om_start  = om_start_q;

endmodule

// File: tb/tb_bit_collect.sv
// Drives two collectors (12-bit and 3-bit address) from one upstream stream
// and checks every frame against an address/data model of the buffer contents.
module tb_bit_collect;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        im_start = 1'b0, im_work = 1'b0, im_data = 1'b0, im_finish = 1'b0;
  logic [11:0] begin_a = '0;

  logic        a_om_work, a_dina, a_wea, a_ovf, a_om_start;
  logic [11:0] a_addra, a_addra_end;
  logic [12:0] a_bit_cnt;
  logic        b_om_work, b_dina, b_wea, b_ovf, b_om_start;
  logic [2:0]  b_addra, b_addra_end;
  logic [3:0]  b_bit_cnt;

  int vectors = 0;
  int miscompares = 0;

  logic [11:0] wa_a[$];
  logic        wd_a[$];
  logic [2:0]  wa_b[$];
  logic        wd_b[$];
  logic        exp_bits[$];
  logic [11:0] frame_base;

  bit_collect #(.ADDR_WIDTH_3(12), .ACK_DELAY(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .im_start(im_start), .im_work(im_work), .im_data(im_data),
    .om_work(a_om_work), .addra(a_addra), .dina(a_dina), .wea(a_wea),
    .addra_begin(begin_a), .addra_end(a_addra_end), .bit_cnt(a_bit_cnt),
    .om_ovf(a_ovf), .om_start(a_om_start), .im_finish(im_finish));

  bit_collect #(.ADDR_WIDTH_3(3), .ACK_DELAY(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .im_start(im_start), .im_work(im_work), .im_data(im_data),
    .om_work(b_om_work), .addra(b_addra), .dina(b_dina), .wea(b_wea),
    .addra_begin(begin_a[2:0]), .addra_end(b_addra_end), .bit_cnt(b_bit_cnt),
    .om_ovf(b_ovf), .om_start(b_om_start), .im_finish(im_finish));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (a_wea === 1'b1) begin wa_a.push_back(a_addra); wd_a.push_back(a_dina); end
    if (b_wea === 1'b1) begin wa_b.push_back(b_addra); wd_b.push_back(b_dina); end
  end

  task automatic start_frame(input logic [11:0] b);
    @(negedge clk);
    begin_a = b; frame_base = b; im_start = 1'b1;
    exp_bits.delete(); wa_a.delete(); wd_a.delete(); wa_b.delete(); wd_b.delete();
    repeat (3) @(negedge clk);
  endtask

  task automatic send_bit(input logic d, input bit drop_start);
    int t;
    im_work = 1'b1; im_data = d; exp_bits.push_back(d);
    if (drop_start) begin @(negedge clk); im_start = 1'b0; end
    t = 0;
    while (a_om_work !== 1'b1 && t < 40) begin @(negedge clk); t++; end
    vectors++;
    if (t >= 40) begin miscompares++; $display("FAIL ack_rise: om_work=%b required 1", a_om_work); end
    if (drop_start) begin
      vectors++;
      if (a_om_start !== 1'b0) begin
        miscompares++; $display("FAIL early_done: om_start=%b required 0 before ack completes", a_om_start);
      end
    end
    im_work = 1'b0; im_data = 1'($urandom);
    t = 0;
    while (a_om_work !== 1'b0 && t < 40) begin @(negedge clk); t++; end
    vectors++;
    if (t >= 40) begin miscompares++; $display("FAIL ack_fall: om_work=%b required 0", a_om_work); end
    if (drop_start) begin
      vectors++;
      if (a_om_start !== 1'b0) begin
        miscompares++; $display("FAIL early_done2: om_start=%b required 0 at ack release", a_om_start);
      end
    end
  endtask

  task automatic end_frame();
    int t, n, m;
    logic [11:0] ea;
    logic [2:0]  eb;
    im_start = 1'b0;
    t = 0;
    while (a_om_start !== 1'b1 && t < 40) begin @(negedge clk); t++; end
    vectors++;
    if (t >= 40) begin miscompares++; $display("FAIL done_wait: om_start=%b required 1", a_om_start); end
    n = exp_bits.size();
    m = (n > 4096) ? 4096 : n;
    ea = (m == 0) ? frame_base : 12'((int'(frame_base) + m - 1) % 4096);
    vectors++;
    if (a_bit_cnt !== 13'(m) || a_ovf !== (n > 4096) || a_addra_end !== ea || wa_a.size() != m) begin
      miscompares++;
      $display("FAIL frame12: bit_cnt=%0d ovf=%b end=%h writes=%0d required %0d %b %h %0d",
               a_bit_cnt, a_ovf, a_addra_end, wa_a.size(), m, (n > 4096), ea, m);
    end
    for (int i = 0; i < m && i < wa_a.size(); i++) begin
      vectors++;
      if (wa_a[i] !== 12'((int'(frame_base) + i) % 4096) || wd_a[i] !== exp_bits[i]) begin
        miscompares++;
        $display("FAIL write12[%0d]: addr=%h data=%b required %h %b", i, wa_a[i], wd_a[i],
                 12'((int'(frame_base) + i) % 4096), exp_bits[i]);
      end
    end
    m = (n > 8) ? 8 : n;
    eb = (m == 0) ? frame_base[2:0] : 3'((int'(frame_base[2:0]) + m - 1) % 8);
    vectors++;
    if (b_om_start !== 1'b1 || b_bit_cnt !== 4'(m) || b_ovf !== (n > 8) || b_addra_end !== eb ||
        wa_b.size() != m) begin
      miscompares++;
      $display("FAIL frame3: start=%b bit_cnt=%0d ovf=%b end=%h writes=%0d required 1 %0d %b %h %0d",
               b_om_start, b_bit_cnt, b_ovf, b_addra_end, wa_b.size(), m, (n > 8), eb, m);
    end
    for (int i = 0; i < m && i < wa_b.size(); i++) begin
      vectors++;
      if (wa_b[i] !== 3'((int'(frame_base[2:0]) + i) % 8) || wd_b[i] !== exp_bits[i]) begin
        miscompares++;
        $display("FAIL write3[%0d]: addr=%h data=%b required %h %b", i, wa_b[i], wd_b[i],
                 3'((int'(frame_base[2:0]) + i) % 8), exp_bits[i]);
      end
    end
    repeat (2) @(negedge clk);
    vectors++;
    if (a_om_start !== 1'b1) begin miscompares++; $display("FAIL start_hold: om_start=%b required 1", a_om_start); end
    im_finish = 1'b1;
    t = 0;
    while (a_om_start !== 1'b0 && t < 40) begin @(negedge clk); t++; end
    vectors++;
    if (t >= 40) begin miscompares++; $display("FAIL finish_wait: om_start=%b required 0", a_om_start); end
    im_finish = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({a_om_work, a_addra, a_dina, a_wea, a_addra_end, a_bit_cnt, a_ovf, a_om_start} !== '0 ||
        {b_om_work, b_addra, b_dina, b_wea, b_addra_end, b_bit_cnt, b_ovf, b_om_start} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: a=%h b=%h required 0",
               {a_om_work, a_addra, a_dina, a_wea, a_addra_end, a_bit_cnt, a_ovf, a_om_start},
               {b_om_work, b_addra, b_dina, b_wea, b_addra_end, b_bit_cnt, b_ovf, b_om_start});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_latency();
    start_frame(12'h3C5);
    im_work = 1'b1; im_data = 1'b1; exp_bits.push_back(1'b1);
    @(negedge clk);
    vectors++;
    if (a_wea !== 1'b0) begin miscompares++; $display("FAIL lat_n: wea=%b required 0", a_wea); end
    @(negedge clk);
    vectors++;
    if (a_wea !== 1'b1 || a_addra !== 12'h3C5 || a_dina !== 1'b1) begin
      miscompares++; $display("FAIL lat_n1: wea=%b addra=%h dina=%b required 1 3c5 1", a_wea, a_addra, a_dina);
    end
    @(negedge clk);
    vectors++;
    if (a_wea !== 1'b0 || a_om_work !== 1'b0) begin
      miscompares++; $display("FAIL lat_n2: wea=%b om_work=%b required 0 0", a_wea, a_om_work);
    end
    @(negedge clk);
    vectors++;
    if (a_om_work !== 1'b1) begin miscompares++; $display("FAIL lat_n3: om_work=%b required 1", a_om_work); end
    im_work = 1'b0;
    repeat (2) @(negedge clk);
    end_frame();
  endtask

  task automatic test_stream();
    start_frame(12'h010);
    send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0);
    end_frame();
  endtask

  task automatic test_late_drop();
    start_frame(12'h7A3);
    send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b1);
    end_frame();
  endtask

  task automatic test_wrap();
    start_frame(12'hFFE);
    send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0);
    end_frame();
  endtask

  task automatic test_overflow();
    start_frame(12'($urandom));
    for (int i = 0; i < 9; i++) send_bit(1'($urandom), 1'b0);
    end_frame();
  endtask

  task automatic test_zero_frame();
    start_frame(12'h2A0);
    end_frame();
  endtask

  task automatic test_rearm();
    int t;
    start_frame(12'h155);
    send_bit(1'b1, 1'b0);
    im_start = 1'b0;
    t = 0;
    while (a_om_start !== 1'b1 && t < 40) begin @(negedge clk); t++; end
    vectors++;
    if (t >= 40) begin miscompares++; $display("FAIL rearm_done: om_start=%b required 1", a_om_start); end
    im_start = 1'b1;
    @(negedge clk);
    im_finish = 1'b1;
    @(negedge clk);
    im_finish = 1'b0;
    wa_a.delete();
    im_work = 1'b1;
    repeat (8) @(negedge clk);
    vectors++;
    if (a_om_work !== 1'b0 || wa_a.size() != 0 || a_om_start !== 1'b0) begin
      miscompares++;
      $display("FAIL rearm_block: om_work=%b writes=%0d om_start=%b required 0 0 0",
               a_om_work, wa_a.size(), a_om_start);
    end
    im_work = 1'b0; im_start = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int t;
    start_frame(12'h123);
    send_bit(1'b1, 1'b0);
    im_work = 1'b1; im_data = 1'b0;
    t = 0;
    while (a_om_work !== 1'b1 && t < 40) begin @(negedge clk); t++; end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (a_om_work !== 1'b0 || a_wea !== 1'b0 || a_om_start !== 1'b0 || a_bit_cnt !== '0 ||
        b_om_work !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid: om_work=%b wea=%b om_start=%b bit_cnt=%0d required 0 0 0 0",
               a_om_work, a_wea, a_om_start, a_bit_cnt);
    end
    im_work = 1'b0; im_start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    start_frame(12'h456);
    send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0);
    end_frame();
  endtask

  task automatic test_random();
    int len;
    for (int f = 0; f < 8; f++) begin
      start_frame(12'($urandom));
      len = $urandom_range(0, 11);
      for (int i = 0; i < len; i++) send_bit(1'($urandom), (i == len - 1) && ($urandom_range(0, 1) == 1));
      end_frame();
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_stream();
    test_late_drop();
    test_wrap();
    test_overflow();
    test_zero_frame();
    test_rearm();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bit_collect.md
Name: bit_collect

Overview:
- Receiving end of the single-bit start/work handshake stream.
- Accepts one data bit per work handshake from an upstream bit-streamer and writes each bit into a 1-bit-wide BRAM, port A.
- Writes run sequentially from addra_begin.
- When the upstream frame ends, reports the frame extent and hands the buffer to the downstream stage with a start/finish handshake.

Parameters:
- ADDR_WIDTH_3, 12: BRAM address width.
- ACK_DELAY, 1: idle cycles between the BRAM write and the om_work assertion (range 0-15).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- im_start  in  1  upstream frame-active level.
- im_work  in  1  upstream bit-valid request.
- im_data  in  1  upstream data bit; valid while im_work=1.
- om_work  out  1  acknowledge to upstream.
- addra  out  ADDR_WIDTH_3  BRAM write address.
- dina  out  1  BRAM write data.
- wea  out  1  BRAM write enable, single-cycle pulse.
- addra_begin  in  ADDR_WIDTH_3  first write address; sampled at frame start.
- addra_end  out  ADDR_WIDTH_3  address of the last bit written; valid while om_start=1.
- bit_cnt  out  ADDR_WIDTH_3+1  bits stored in the current frame.
- om_ovf  out  1  frame exceeded 2^ADDR_WIDTH_3 bits.
- om_start  out  1  downstream: buffer ready.
- im_finish  in  1  downstream: buffer consumed.

Behaviour:
- Reset: all outputs are 0, and the state is IDLE. Reset applies asynchronously from any state; no write is in flight after reset is released.
- All outputs are registered.
- States: IDLE, ARM, WAIT_BIT, WRITE, DLY, ACK, WAIT_LOW, DONE, RELEASE.
- IDLE: on im_start=1, latch addra_begin into a base register, clear bit_cnt and om_ovf, set first=1, and go to ARM.
- ARM: one cycle, then WAIT_BIT.
- WAIT_BIT:
  - im_work=1 has priority. Capture im_data into dina and go to WRITE.
  - Otherwise, if im_start=0, the frame has ended: go to DONE.
  - im_start may fall one cycle after the last im_work rise. That last bit must still be stored.
- WRITE:
  - If bit_cnt < 2^ADDR_WIDTH_3: wea=1 for this cycle only. addra = base if first, else previous addra+1 (modulo 2^ADDR_WIDTH_3, wraps). bit_cnt increments, first is cleared, and addra_end takes the written address.
  - Otherwise: wea stays 0, om_ovf=1 (sticky until the next frame start), and the bit is dropped but still acknowledged.
  - Next state: DLY.
- DLY: count ACK_DELAY cycles (0 means pass straight through), then ACK.
- ACK: om_work<=1, then WAIT_LOW.
- WAIT_LOW: hold om_work=1 until im_work=0, then om_work<=0 and return to WAIT_BIT.
- Latency: with ACK_DELAY=1, im_work sampled high at edge N gives wea high during N+1..N+2 and om_work high from edge N+3.
- DONE:
  - om_start<=1 and hold.
  - On im_finish=1: om_start<=0 and go to RELEASE.
  - A zero-bit frame (im_start drops with no work) still raises om_start, with bit_cnt=0 and addra_end=base.
- RELEASE:
  - Wait for im_finish=0 and im_start=0, then go to IDLE.
  - A new im_start that is still high after release is not re-armed until it has been seen low.
- im_work asserted while the state is outside WAIT_BIT is ignored until WAIT_BIT is reached. The upstream protocol never does this.
- addra, dina and addra_end hold their values outside WRITE.

Decomposition:
- Shared package: state encoding localparams (reused by the streamer side) and the handshake-phase constants.
- One natural sub-module: bit_collect_ack_timer, the ACK_DELAY down-counter with load/done.
- The rest stays flat.

Test Plan:
- Stream bits 1,0,1,1 with addra_begin=0x010 → wea pulses at 0x010–0x013 with dina 1,0,1,1; bit_cnt=4; addra_end=0x013; om_start=1 until im_finish.
- Last bit sent with im_start dropping one cycle after im_work rises → bit stored; bit_cnt correct; DONE entered only after the ack completes.
- addra_begin=0xFFE, 3 bits → writes at 0xFFE, 0xFFF, 0x000; addra_end=0x000.
- ADDR_WIDTH_3=3, 9 bits → 8 writes; 9th bit acknowledged with no wea; om_ovf=1; bit_cnt=8.
- im_start pulsed with no im_work → om_start=1, bit_cnt=0; next frame needs im_start low then high.
- rst_n asserted while in WAIT_LOW → om_work, wea, om_start go 0 immediately; the next frame starts clean at the new addra_begin.
